rice_bus_arbiter: RTL and testbench

//  Two-master, one-slave arbiter for the core's memory side. Sits directly

---
 rtl/rice_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_rice_bus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rice_bus_arbiter.sv
// rtl/rice_bus_arbiter.sv - two-master, one-slave memory bus arbiter with in-order response routing
//
// Merges the instruction bus (master 0) and the data bus (master 1) onto one
// memory port. Requests and responses pass through combinationally. A small
// order FIFO records which master owns each outstanding request so in-order
// responses can be steered back to the right master.
//
// Ports
//   i_clk, i_rst         clock; asynchronous active-high reset
//   i_m_req_*            per-master request (valid/write/address/wdata/strobe), master n in slice n
//   o_m_req_ready        per-master request accept
//   o_m_resp_valid       per-master response valid
//   i_m_resp_ready       per-master response ready
//   o_m_resp_data/error  shared response payload, qualified by o_m_resp_valid
//   o_s_req_*            slave request (valid/write/address/wdata/strobe)
//   i_s_req_ready        slave request ready
//   i_s_resp_*           slave response (valid/data/error)
//   o_s_resp_ready       slave response ready
module rice_bus_arbiter #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_PRIORITY   = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [1:0]                    i_m_req_valid,
    output logic [1:0]                    o_m_req_ready,
    input  logic [1:0]                    i_m_req_write,
    input  logic [2*ADDRESS_WIDTH-1:0]    i_m_req_address,
    input  logic [2*DATA_WIDTH-1:0]       i_m_req_wdata,
    input  logic [2*(DATA_WIDTH/8)-1:0]   i_m_req_strobe,
    output logic [1:0]                    o_m_resp_valid,
    input  logic [1:0]                    i_m_resp_ready,
    output logic [DATA_WIDTH-1:0]         o_m_resp_data,
    output logic                          o_m_resp_error,
    output logic                          o_s_req_valid,
    input  logic                          i_s_req_ready,
    output logic                          o_s_req_write,
    output logic [ADDRESS_WIDTH-1:0]      o_s_req_address,
    output logic [DATA_WIDTH-1:0]         o_s_req_wdata,
    output logic [(DATA_WIDTH/8)-1:0]     o_s_req_strobe,
    input  logic                          i_s_resp_valid,
    output logic                          o_s_resp_ready,
    input  logic [DATA_WIDTH-1:0]         i_s_resp_data,
    input  logic                          i_s_resp_error
);

    localparam int AW    = ADDRESS_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int SW    = DATA_WIDTH / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       lock_gnt;
    logic                       last_gnt;
    logic                       grant;
    logic                       req_valid;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic                       head;
    logic                       resp_ready;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [MAX_OUTSTANDING-1:0] order_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNT_W'(MAX_OUTSTANDING));
    assign empty = (count == '0);

    // Grant selection. A stalled request keeps its grant so the slave sees a
    // stable payload; otherwise a lone requester wins, and a tie goes to the
    // data bus (fixed priority) or to whoever was not served last.
    always_comb begin
        grant = ~last_gnt;
        if (state == ST_LOCKED) begin
            grant = lock_gnt;
        end else if (i_m_req_valid == 2'b01) begin
            grant = 1'b0;
        end else if (i_m_req_valid == 2'b10) begin
            grant = 1'b1;
        end else if (DATA_PRIORITY != 0) begin
            grant = 1'b1;
        end
    end

    // Full blocks acceptance even if a response pops in the same cycle, which
    // keeps the ready path independent of the response handshake.
    assign req_valid = i_m_req_valid[grant] & ~full & ~i_rst;
    assign push      = req_valid & i_s_req_ready;

    assign o_s_req_valid   = req_valid;
    assign o_s_req_write   = i_m_req_write[grant];
    assign o_s_req_address = grant ? i_m_req_address[AW +: AW] : i_m_req_address[0 +: AW];
    assign o_s_req_wdata   = grant ? i_m_req_wdata[DW +: DW]   : i_m_req_wdata[0 +: DW];
    assign o_s_req_strobe  = grant ? i_m_req_strobe[SW +: SW]  : i_m_req_strobe[0 +: SW];

    always_comb begin
        o_m_req_ready = 2'b00;
        if (~full && ~i_rst) begin
            o_m_req_ready[grant] = i_s_req_ready;
        end
    end

    // Response steering: the FIFO head names the master owning the oldest
    // outstanding request.
    assign head       = order_q[rd_ptr];
    assign resp_ready = i_m_resp_ready[head] & ~empty & ~i_rst;
    assign pop        = i_s_resp_valid & resp_ready;

    assign o_s_resp_ready = resp_ready;
    assign o_m_resp_data  = i_s_resp_data;
    assign o_m_resp_error = i_s_resp_error;

    always_comb begin
        o_m_resp_valid = 2'b00;
        if (~empty && ~i_rst) begin
            o_m_resp_valid[head] = i_s_resp_valid;
        end
    end

    // Grant lock FSM: locked while the slave has not yet taken the offered request.
    always_comb begin
        state_next = ST_OPEN;
        if (req_valid && !i_s_req_ready) begin
            state_next = ST_LOCKED;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_OPEN;
            lock_gnt <= 1'b0;
        end else begin
            state    <= state_next;
            lock_gnt <= grant;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_gnt <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            order_q  <= '0;
        end else begin
            if (push) begin
                order_q[wr_ptr] <= grant;
                wr_ptr          <= ptr_inc(wr_ptr);
                last_gnt        <= grant;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A slave response with nothing outstanding has no owner and is left unconsumed.
    resp_while_empty: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_s_resp_valid && empty));

endmodule

// File: tb/tb_rice_bus_arbiter.sv
// tb/tb_rice_bus_arbiter.sv - self-checking bench for rice_bus_arbiter (round-robin and fixed-priority instances)
module tb_rice_bus_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]  m_req_valid   [2];
    logic [1:0]  m_req_write   [2];
    logic [63:0] m_req_address [2];
    logic [63:0] m_req_wdata   [2];
    logic [7:0]  m_req_strobe  [2];
    logic [1:0]  m_resp_ready  [2];
    logic        s_req_ready   [2];
    logic        s_resp_valid  [2];
    logic [31:0] s_resp_data   [2];
    logic        s_resp_error  [2];

    logic [1:0]  m_req_ready   [2];
    logic [1:0]  m_resp_valid  [2];
    logic [31:0] m_resp_data   [2];
    logic        m_resp_error  [2];
    logic        s_req_valid   [2];
    logic        s_req_write   [2];
    logic [31:0] s_req_address [2];
    logic [31:0] s_req_wdata   [2];
    logic [3:0]  s_req_strobe  [2];
    logic        s_resp_ready  [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0 is round-robin, instance 1 gives the data bus fixed priority.
    for (genvar k = 0; k < 2; k++) begin : g_dut
        rice_bus_arbiter #(
            .ADDRESS_WIDTH  (32),
            .DATA_WIDTH     (32),
            .MAX_OUTSTANDING(2),
            .DATA_PRIORITY  (k)
        ) u_dut (
            .i_clk          (clk),
            .i_rst          (rst),
            .i_m_req_valid  (m_req_valid[k]),
            .o_m_req_ready  (m_req_ready[k]),
            .i_m_req_write  (m_req_write[k]),
            .i_m_req_address(m_req_address[k]),
            .i_m_req_wdata  (m_req_wdata[k]),
            .i_m_req_strobe (m_req_strobe[k]),
            .o_m_resp_valid (m_resp_valid[k]),
            .i_m_resp_ready (m_resp_ready[k]),
            .o_m_resp_data  (m_resp_data[k]),
            .o_m_resp_error (m_resp_error[k]),
            .o_s_req_valid  (s_req_valid[k]),
            .i_s_req_ready  (s_req_ready[k]),
            .o_s_req_write  (s_req_write[k]),
            .o_s_req_address(s_req_address[k]),
            .o_s_req_wdata  (s_req_wdata[k]),
            .o_s_req_strobe (s_req_strobe[k]),
            .i_s_resp_valid (s_resp_valid[k]),
            .o_s_resp_ready (s_resp_ready[k]),
            .i_s_resp_data  (s_resp_data[k]),
            .i_s_resp_error (s_resp_error[k])
        );
    end

    task automatic chk(input int k, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h expected %0h at %0t", k, name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        m_req_valid[k]   = v;
        m_req_address[k] = {a1, a0};
        m_req_wdata[k]   = {a1 ^ 32'h5A5A_5A5A, a0 ^ 32'hA5A5_A5A5};
    endtask

    // Reference model: owners of outstanding requests in a queue, plus the
    // arbitration memory (who was served last, and a frozen grant while stalled).
    int  owner_q [2][$];
    int  last_g  [2];
    bit  frozen  [2];
    int  frozen_g[2];
    bit  ev_push [2];
    bit  ev_pop  [2];
    bit  ev_stall[2];
    int  ev_g    [2];

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int g;
                int h;
                bit full;
                bit empty;
                bit sv;
                bit acc;
                bit rr;
                bit rv;
                if (rst) begin
                    owner_q[k].delete();
                    last_g[k]   = 1;
                    frozen[k]   = 0;
                    ev_push[k]  = 0;
                    ev_pop[k]   = 0;
                    ev_stall[k] = 0;
                    chk(k, "rst_s_req_valid", s_req_valid[k], 0);
                    chk(k, "rst_m_req_ready", m_req_ready[k], 0);
                    chk(k, "rst_m_resp_valid", m_resp_valid[k], 0);
                    chk(k, "rst_s_resp_ready", s_resp_ready[k], 0);
                end else begin
                    full  = (owner_q[k].size() == 2);
                    empty = (owner_q[k].size() == 0);
                    if (frozen[k])                    g = frozen_g[k];
                    else if (m_req_valid[k] == 2'b01) g = 0;
                    else if (m_req_valid[k] == 2'b10) g = 1;
                    else if (k == 1)                  g = 1;
                    else                              g = 1 - last_g[k];
                    sv  = m_req_valid[k][g] && !full;
                    acc = sv && s_req_ready[k];
                    chk(k, "s_req_valid", s_req_valid[k], sv);
                    chk(k, "req_handshake", m_req_ready[k] & m_req_valid[k], acc ? (2'b01 << g) : 2'b00);
                    if (sv) begin
                        chk(k, "s_req_address", s_req_address[k], (g == 1) ? m_req_address[k][63:32] : m_req_address[k][31:0]);
                        chk(k, "s_req_wdata", s_req_wdata[k], (g == 1) ? m_req_wdata[k][63:32] : m_req_wdata[k][31:0]);
                        chk(k, "s_req_strobe", s_req_strobe[k], (g == 1) ? m_req_strobe[k][7:4] : m_req_strobe[k][3:0]);
                        chk(k, "s_req_write", s_req_write[k], m_req_write[k][g]);
                    end
                    h  = empty ? 0 : owner_q[k][0];
                    rr = !empty && m_resp_ready[k][h];
                    rv = !empty && s_resp_valid[k];
                    chk(k, "s_resp_ready", s_resp_ready[k], rr);
                    chk(k, "m_resp_valid", m_resp_valid[k], rv ? (2'b01 << h) : 2'b00);
                    if (rv) begin
                        chk(k, "m_resp_data", m_resp_data[k], s_resp_data[k]);
                        chk(k, "m_resp_error", m_resp_error[k], s_resp_error[k]);
                    end
                    ev_push[k]  = acc;
                    ev_pop[k]   = s_resp_valid[k] && rr;
                    ev_stall[k] = sv && !s_req_ready[k];
                    ev_g[k]     = g;
                end
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst) begin
                    if (ev_pop[k]) void'(owner_q[k].pop_front());
                    if (ev_push[k]) begin
                        owner_q[k].push_back(ev_g[k]);
                        last_g[k] = ev_g[k];
                    end
                    frozen[k]   = ev_stall[k];
                    frozen_g[k] = ev_g[k];
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_req(k, 2'b00, 32'h0, 32'h0);
            m_req_write[k]  = 2'b10;
            m_req_strobe[k] = 8'h3F;
            m_resp_ready[k] = 2'b11;
            s_req_ready[k]  = 1'b1;
            s_resp_valid[k] = 1'b0;
            s_resp_data[k]  = 32'h0;
            s_resp_error[k] = 1'b0;
        end
        set_req(0, 2'b11, 32'h1000, 32'h2000);
        #3;
        chk(0, "reset_s_req_valid", s_req_valid[0], 0);
        chk(0, "reset_m_req_ready", m_req_ready[0], 0);
        step;
        step;
        rst = 1'b0;

        // 1: tie at first cycle goes to master 0, then master 1; responses 01 then 10
        #1;
        chk(0, "t1_addr0", s_req_address[0], 32'h1000);
        chk(0, "t1_ready0", m_req_ready[0], 2'b01);
        step;
        set_req(0, 2'b10, 32'h1000, 32'h2000);
        #1;
        chk(0, "t1_addr1", s_req_address[0], 32'h2000);
        chk(0, "t1_ready1", m_req_ready[0], 2'b10);
        step;
        set_req(0, 2'b00, 32'h0, 32'h0);
        s_resp_valid[0] = 1'b1;
        s_resp_data[0]  = 32'hAAAA_0001;
        #1;
        chk(0, "t1_resp0", m_resp_valid[0], 2'b01);
        chk(0, "t1_resp0_data", m_resp_data[0], 32'hAAAA_0001);
        step;
        s_resp_data[0]  = 32'hAAAA_0002;
        s_resp_error[0] = 1'b1;
        #1;
        chk(0, "t1_resp1", m_resp_valid[0], 2'b10);
        step;
        s_resp_valid[0] = 1'b0;
        s_resp_error[0] = 1'b0;

        // serve master 0 alone so that round-robin would next favour master 1
        set_req(0, 2'b01, 32'h1004, 32'h0);
        #1;
        chk(0, "pre_ready", m_req_ready[0], 2'b01);
        step;
        set_req(0, 2'b00, 32'h0, 32'h0);
        s_resp_valid[0] = 1'b1;
        #1;
        chk(0, "pre_resp", m_resp_valid[0], 2'b01);
        step;
        s_resp_valid[0] = 1'b0;

        // 2: slave stalls 3 cycles; master 1 arrives but grant stays on master 0
        s_req_ready[0] = 1'b0;
        set_req(0, 2'b01, 32'h3000, 32'h3004);
        #1;
        chk(0, "t2_addr_c1", s_req_address[0], 32'h3000);
        chk(0, "t2_ready_c1", m_req_ready[0], 2'b00);
        for (int i = 0; i < 2; i++) begin
            step;
            set_req(0, 2'b11, 32'h3000, 32'h3004);
            #1;
            chk(0, "t2_addr_locked", s_req_address[0], 32'h3000);
            chk(0, "t2_valid_locked", s_req_valid[0], 1);
        end
        step;
        s_req_ready[0] = 1'b1;
        #1;
        chk(0, "t2_hs_ready", m_req_ready[0], 2'b01);
        chk(0, "t2_hs_addr", s_req_address[0], 32'h3000);
        step;
        set_req(0, 2'b10, 32'h3000, 32'h3004);
        #1;
        chk(0, "t2_m1_ready", m_req_ready[0], 2'b10);
        chk(0, "t2_m1_addr", s_req_address[0], 32'h3004);
        step;
        set_req(0, 2'b00, 32'h0, 32'h0);

        // 3: two outstanding -> third request blocked, even during the pop cycle
        set_req(0, 2'b01, 32'h4000, 32'h0);
        #1;
        chk(0, "t3_full_ready", m_req_ready[0], 2'b00);
        chk(0, "t3_full_valid", s_req_valid[0], 0);
        step;
        s_resp_valid[0] = 1'b1;
        #1;
        chk(0, "t3_pop_ready", m_req_ready[0], 2'b00);
        chk(0, "t3_pop_resp", m_resp_valid[0], 2'b01);
        step;
        s_resp_valid[0] = 1'b0;
        #1;
        chk(0, "t3_after_ready", m_req_ready[0], 2'b01);
        chk(0, "t3_after_addr", s_req_address[0], 32'h4000);
        step;
        set_req(0, 2'b00, 32'h0, 32'h0);

        // 4: head is master 1 but only master 0 is ready -> no pop until ready[1]
        m_resp_ready[0] = 2'b01;
        s_resp_valid[0] = 1'b1;
        #1;
        chk(0, "t4_resp_valid", m_resp_valid[0], 2'b10);
        chk(0, "t4_s_ready", s_resp_ready[0], 0);
        step;
        #1;
        chk(0, "t4_hold_valid", m_resp_valid[0], 2'b10);
        chk(0, "t4_hold_ready", s_resp_ready[0], 0);
        step;
        m_resp_ready[0] = 2'b11;
        #1;
        chk(0, "t4_pop_ready", s_resp_ready[0], 1);
        step;
        #1;
        chk(0, "t4_next_head", m_resp_valid[0], 2'b01);
        step;
        s_resp_valid[0] = 1'b0;

        // 6: asynchronous reset with two outstanding
        set_req(0, 2'b11, 32'h5000, 32'h5004);
        #1;
        chk(0, "t6_ready_a", m_req_ready[0], 2'b10);
        step;
        set_req(0, 2'b01, 32'h5000, 32'h5004);
        #1;
        chk(0, "t6_ready_b", m_req_ready[0], 2'b01);
        step;
        set_req(0, 2'b11, 32'h5000, 32'h5004);
        s_resp_valid[0] = 1'b1;
        #1;
        chk(0, "t6_pre_rst_resp", m_resp_valid[0], 2'b10);
        rst = 1'b1;
        #1;
        chk(0, "t6_rst_s_req_valid", s_req_valid[0], 0);
        chk(0, "t6_rst_m_req_ready", m_req_ready[0], 0);
        chk(0, "t6_rst_m_resp_valid", m_resp_valid[0], 0);
        chk(0, "t6_rst_s_resp_ready", s_resp_ready[0], 0);
        step;
        s_resp_valid[0] = 1'b0;
        set_req(0, 2'b00, 32'h0, 32'h0);
        #1;
        rst = 1'b0;
        set_req(0, 2'b10, 32'h0, 32'h5008);
        #1;
        chk(0, "t6_new_ready", m_req_ready[0], 2'b10);
        chk(0, "t6_new_addr", s_req_address[0], 32'h5008);
        step;
        set_req(0, 2'b00, 32'h0, 32'h0);
        s_resp_valid[0] = 1'b1;
        #1;
        chk(0, "t6_new_resp", m_resp_valid[0], 2'b10);
        step;
        s_resp_valid[0] = 1'b0;

        // 5: fixed priority instance, both valid for 4 cycles
        set_req(1, 2'b11, 32'h6000, 32'h7000);
        #1;
        chk(1, "t5_addr_c0", s_req_address[1], 32'h7000);
        chk(1, "t5_ready_c0", m_req_ready[1], 2'b10);
        for (int i = 0; i < 3; i++) begin
            step;
            s_resp_valid[1] = 1'b1;
            s_resp_data[1]  = 32'h7000_0000 + i;
            #1;
            chk(1, "t5_addr", s_req_address[1], 32'h7000);
            chk(1, "t5_ready", m_req_ready[1], 2'b10);
            chk(1, "t5_resp", m_resp_valid[1], 2'b10);
        end
        step;
        set_req(1, 2'b01, 32'h6000, 32'h7000);
        #1;
        chk(1, "t5_m0_addr", s_req_address[1], 32'h6000);
        chk(1, "t5_m0_ready", m_req_ready[1], 2'b01);
        step;
        set_req(1, 2'b00, 32'h0, 32'h0);
        #1;
        chk(1, "t5_m0_resp", m_resp_valid[1], 2'b01);
        step;
        s_resp_valid[1] = 1'b0;
        step;
        step;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
